onehot_decoder_disp: RTL and testbench
======================================

# onehot_decoder_disp

Board-side 3-to-8 decoder that consumes a 4-bit priority code {valid, index[2:0]} produced by the switch-side priority encoder. It captures the code on a debounced button press, drives a one-hot LED pattern and a seven-segment digit, and keeps a capture counter. An invalid code (valid=0) makes the low LEDs blink. It sits between the encoder output and the board LED/segment pins.

## Interface
- DEB_CYCLES, 20: consecutive cycles a synchronized button level must differ from the debounced level before the debounced level flips; must be ≥1.
- BLINK_CYCLES, 5000000: blink half-period in cycles; must be ≥2.
- clk  in  1  single clock domain.
- rst  in  1  reset, asynchronous and active-low.
- code_i  in  4  {valid, index[2:0]}; sampled only on capture.
- btn_i  in  1  raw capture button, asynchronous, active-high.
- ledr  out  16  [7:0] decoded pattern; [15:8] capture count.
- seg0  out  8  active-low segments; bit0=a … bit6=g, bit7=dp.

## Operation
- Sync: btn_i passes through a 2-flop synchronizer to give btn_s.
- Debounce: a counter increments on every edge where btn_s ≠ deb. On the edge where the counter equals DEB_CYCLES-1 and the levels still differ, deb flips and the counter clears. The counter also clears on any edge where btn_s == deb, so a glitch restarts the count.
- Capture pulse: one cycle, on the 0→1 transition of deb (deb & ~deb_d). A release (1→0) produces no pulse.
- On a capture pulse:
  - code_q ← code_i.
  - cap_cnt ← cap_cnt+1, 8-bit, wraps 255→0.
  - Blink counter and blink phase clear to 0.
- Blink: runs only while code_q[3]=0. The counter counts 0..BLINK_CYCLES-1; on wrap, phase toggles. While code_q[3]=1, the counter and phase are held at 0.
- ledr[7:0]:
  - Valid code: 1<<code_q[2:0].
  - Invalid code: 8'hFF when phase=1, else 8'h00.
- ledr[15:8] = cap_cnt.
- seg0 digit codes for index 0–7: C0, F9, A4, B0, 99, 92, 82, F8 (hex). Invalid code shows dash: BF. dp is always off.
- Reset (rst=0, async): sync flops, deb, deb_d and all counters go to 0; code_q=4'h0. ledr=16'h0000, seg0=8'hBF.
- Reset mid-debounce or mid-blink abandons that activity. After release, a held button must complete a full debounce before it captures.

## Timing
- All outputs are registered. They are a pure function of code_q, cap_cnt and phase, delayed by one cycle.
- Capture latency: count edge 0 as the first edge sampling btn_i=1, with btn_i held high.
  - edge 1: btn_s=1.
  - edge DEB_CYCLES+1: deb=1.
  - edge DEB_CYCLES+2: code_q/cap_cnt load.
  - edge DEB_CYCLES+3: ledr/seg0 show the new value.
- code_i must be stable at edge DEB_CYCLES+2. Changes at any other time have no effect.
- Blink: phase toggles every BLINK_CYCLES edges, counted from capture or from reset release. ledr lags phase by one edge.
- A capture pulse and a blink wrap on the same edge: the capture wins (phase=0, counter=0).
- Re-press: requires deb to return to 0 (a debounced release) and then a full debounce to 1.

## Structure
- Shared package holds:
  - the seven-segment constants for digits 0–7 and the dash, as named 8-bit localparams;
  - the code field widths (valid bit position 3, index width 3).
- One sub-module: btn_debounce (synchronizer, debounce counter, rising-edge pulse), parameterized by DEB_CYCLES.
- Decode, blink, counter and output registers live in the top module.

## Test plan
All scenarios use DEB_CYCLES=4, BLINK_CYCLES=8.
- Reset → ledr=16'h0000 and seg0=8'hBF. After 8 edges ledr[7:0] is FF; after 8 more it is 00.
- code_i=4'hD, btn_i held high from edge 0 → at edge 7 ledr=16'h0120 and seg0=8'h92. Nothing changes before edge 7.
- btn_i high for 3 edges, low for 1, repeated → no capture ever; ledr[15:8] stays 00.
- 256 clean presses with code_i=4'h8 → ledr[15:8] wraps to 00, ledr[7:0]=01, seg0=C0.
- Capture code_i=4'h3 (invalid) → ledr[7:0] blinks with period 16 and seg0=BF. A later capture of 4'hF → ledr[7:0]=80 steady and seg0=F8.
- rst asserted 2 cycles after btn_i rises, then released with btn_i still high → no capture until a full debounce completes (edges 0–7 counted from release); cap_cnt ends at 1.

Source files
------------

// File: rtl/onehot_decoder_disp_pkg.sv
// ============================================================================
// Module   : onehot_decoder_disp_pkg
// Brief    : Shared code-field widths and seven-segment patterns for the
//            board-side one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package onehot_decoder_disp_pkg;

  localparam int c_code_w    = 4;
  localparam int c_valid_bit = 3;
  localparam int c_idx_w     = 3;

  // Active-low segments, bit0=a .. bit6=g, bit7=dp (kept off)
  localparam logic [7:0] c_seg_0    = 8'hC0;
  localparam logic [7:0] c_seg_1    = 8'hF9;
  localparam logic [7:0] c_seg_2    = 8'hA4;
  localparam logic [7:0] c_seg_3    = 8'hB0;
  localparam logic [7:0] c_seg_4    = 8'h99;
  localparam logic [7:0] c_seg_5    = 8'h92;
  localparam logic [7:0] c_seg_6    = 8'h82;
  localparam logic [7:0] c_seg_7    = 8'hF8;
  localparam logic [7:0] c_seg_dash = 8'hBF;

  function automatic logic [7:0] seg_digit(input logic [c_idx_w-1:0] idx);
    logic [7:0] seg;
    case (idx)
      3'd0:    seg = c_seg_0;
      3'd1:    seg = c_seg_1;
      3'd2:    seg = c_seg_2;
      3'd3:    seg = c_seg_3;
      3'd4:    seg = c_seg_4;
      3'd5:    seg = c_seg_5;
      3'd6:    seg = c_seg_6;
      default: seg = c_seg_7;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_decoder_disp_btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Brief    : Button synchronizer, run-length debouncer and press pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_deb,
  output logic o_pulse
);

  localparam int             c_cnt_w   = $clog2(DEB_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_deb;
  logic               r_deb_d;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      // Any cycle where the levels agree restarts the run
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign o_deb   = r_deb;
  assign o_pulse = r_deb & ~r_deb_d;

endmodule

`default_nettype wire

// File: rtl/onehot_decoder_disp.sv
// ============================================================================
// Module   : onehot_decoder_disp
// Brief    : Captures a priority code on a debounced press and drives one-hot
//            LEDs, a capture count and a seven-segment digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_decoder_disp
  import onehot_decoder_disp_pkg::*;
#(
  parameter int DEB_CYCLES   = 20,
  parameter int BLINK_CYCLES = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [c_code_w-1:0] code_i,
  input  logic                btn_i,
  output logic [15:0]         ledr,
  output logic [7:0]          seg0
);

  localparam int               c_blink_w   = $clog2(BLINK_CYCLES);
  localparam logic [c_blink_w-1:0] c_blink_max = c_blink_w'(BLINK_CYCLES - 1);

  logic                w_pulse;
  logic                w_deb;
  logic [c_code_w-1:0] r_code_q;
  logic [7:0]          r_cap_cnt;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                r_phase;
  logic [15:0]         r_ledr;
  logic [7:0]          r_seg0;
  logic [7:0]          w_led_lo;
  logic [7:0]          w_seg;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_i),
    .o_deb   (w_deb),
    .o_pulse (w_pulse)
  );

  always_comb begin
    w_led_lo = 8'h00;
    w_seg    = c_seg_dash;
    if (r_code_q[c_valid_bit]) begin
      w_led_lo = 8'h01 << r_code_q[c_idx_w-1:0];
      w_seg    = seg_digit(r_code_q[c_idx_w-1:0]);
    end else if (r_phase) begin
      w_led_lo = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_code_q    <= '0;
      r_cap_cnt   <= 8'h00;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_ledr      <= 16'h0000;
      r_seg0      <= c_seg_dash;
    end else begin
      r_ledr <= {r_cap_cnt, w_led_lo};
      r_seg0 <= w_seg;
      // A capture outranks a blink wrap landing on the same edge
      if (w_pulse) begin
        r_code_q    <= code_i;
        r_cap_cnt   <= r_cap_cnt + 8'd1;
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end else if (!r_code_q[c_valid_bit]) begin
        if (r_blink_cnt == c_blink_max) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
        end
      end else begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end
    end
  end

  assign ledr = r_ledr;
  assign seg0 = r_seg0;

  logic w_unused;
  assign w_unused = w_deb;

endmodule

`default_nettype wire

// File: tb/tb_onehot_decoder_disp.sv
// ============================================================================
// Module   : tb_onehot_decoder_disp
// Brief    : Self-checking bench with a cycle reference model and random presses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_decoder_disp;

  localparam int DEB   = 4;
  localparam int BLINK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  code_i = 4'h0;
  logic        btn_i = 1'b0;
  logic [15:0] ledr;
  logic [7:0]  seg0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  logic [7:0] seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  onehot_decoder_disp #(
    .DEB_CYCLES   (DEB),
    .BLINK_CYCLES (BLINK)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .code_i (code_i),
    .btn_i  (btn_i),
    .ledr   (ledr),
    .seg0   (seg0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: btn history and "consecutive disagreeing edges" run length
  bit         m_hist [2];
  bit         m_deb, m_deb_prev;
  int         m_run;
  logic [3:0] m_code;
  int         m_cap;
  int         m_edges;
  bit         m_phase;
  logic [15:0] m_ledr;
  logic [7:0]  m_seg;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hist = '{0, 0};
      m_deb = 0; m_deb_prev = 0; m_run = 0;
      m_code = 4'h0; m_cap = 0; m_edges = 0; m_phase = 0;
      m_ledr = 16'h0000; m_seg = 8'hBF;
    end else begin
      bit press;
      m_ledr[15:8] = 8'(m_cap % 256);
      if (m_code[3]) begin
        m_ledr[7:0] = 8'(1 << m_code[2:0]);
        m_seg = seg_tab[m_code[2:0]];
      end else begin
        m_ledr[7:0] = m_phase ? 8'hFF : 8'h00;
        m_seg = 8'hBF;
      end
      press = m_deb && !m_deb_prev;
      if (press) begin
        m_edges = 0; m_phase = 0;
        m_code = code_i; m_cap++;
      end else if (!m_code[3]) begin
        m_edges++;
        if (m_edges == BLINK) begin m_edges = 0; m_phase = !m_phase; end
      end else begin
        m_edges = 0; m_phase = 0;
      end
      m_deb_prev = m_deb;
      if (m_hist[1] != m_deb) begin
        m_run++;
        if (m_run == DEB) begin m_deb = !m_deb; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_hist[1] = m_hist[0];
      m_hist[0] = btn_i;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("ledr_model", ledr, m_ledr);
      check("seg0_model", {8'h00, seg0}, {8'h00, m_seg});
    end
  end

  task automatic press(input logic [3:0] code);
    @(negedge clk); code_i = code; btn_i = 1'b1;
    repeat (10) @(negedge clk);
    btn_i = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check("reset_ledr", ledr, 16'h0000);
    check("reset_seg0", {8'h00, seg0}, 16'h00BF);
    repeat (3) @(negedge clk);
    check("reset_hold_ledr", ledr, 16'h0000);
    chk_en = 1'b1;
    rst = 1'b1;

    // Blink from reset release, ledr one edge behind phase
    repeat (9) @(posedge clk);
    #1 check("blink_on", {8'h00, ledr[7:0]}, 16'h00FF);
    repeat (8) @(posedge clk);
    #1 check("blink_off", {8'h00, ledr[7:0]}, 16'h0000);

    // Capture latency for code D
    @(negedge clk); code_i = 4'hD; btn_i = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("pre_capture_cnt", {8'h00, ledr[15:8]}, 16'h0000);
    @(posedge clk);
    #1 check("capture_ledr", ledr, 16'h0120);
    check("capture_seg0", {8'h00, seg0}, 16'h0092);
    @(negedge clk); btn_i = 1'b0;
    repeat (10) @(negedge clk);

    // Glitchy presses never reach the debounce threshold
    for (int i = 0; i < 10; i++) begin
      btn_i = 1'b1; repeat (3) @(negedge clk);
      btn_i = 1'b0; @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("glitch_cnt", {8'h00, ledr[15:8]}, 16'h0001);

    // Counter wrap: 255 more presses make 256 total
    for (int i = 0; i < 255; i++) press(4'h8);
    check("wrap_ledr", ledr, 16'h0001);
    check("wrap_seg0", {8'h00, seg0}, 16'h00C0);

    // Invalid code blinks, then a valid code holds steady
    press(4'h3);
    check("invalid_seg0", {8'h00, seg0}, 16'h00BF);
    repeat (40) @(negedge clk);
    press(4'hF);
    check("idx7_led", {8'h00, ledr[7:0]}, 16'h0080);
    check("idx7_seg0", {8'h00, seg0}, 16'h00F8);
    repeat (20) @(negedge clk);
    check("idx7_steady", {8'h00, ledr[7:0]}, 16'h0080);

    // Reset mid-debounce; a held button needs a fresh full debounce
    @(negedge clk); code_i = 4'hA; btn_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 check("midreset_ledr", ledr, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("rst_pre_capture", {8'h00, ledr[15:8]}, 16'h0000);
    @(posedge clk);
    #1 check("rst_capture_ledr", ledr, 16'h0104);
    check("rst_capture_seg0", {8'h00, seg0}, 16'h00A4);
    @(negedge clk); btn_i = 1'b0;
    repeat (10) @(negedge clk);

    // Random button runs and random codes against the model
    for (int i = 0; i < 120; i++) begin
      int len;
      bit lvl;
      len = $urandom_range(1, 10);
      lvl = 1'($urandom_range(0, 1));
      repeat (len) begin
        @(negedge clk);
        btn_i  = lvl;
        code_i = 4'($urandom);
      end
    end
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
